// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 8;
    localparam int TICK_W       = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_SAMPLE = TICK_W'(SAMPLE_POINT - 1);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);

    typedef enum logic [2:0] {
        TX_ST_IDLE,
        TX_ST_START,
        TX_ST_DATA,
        TX_ST_PARITY,
        TX_ST_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_ST_IDLE,
        RX_ST_START,
        RX_ST_DATA,
        RX_ST_PARITY,
        RX_ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty derived from an extra pointer MSB.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// UART with TX/RX FIFOs, 16x oversampling baud generator and TX/RX framing FSMs.
//  state  | meaning
//  IDLE   | line idle, waiting for a FIFO word (TX) or a start edge (RX)
//  START  | start bit period
//  DATA   | DATA_W data bits, LSB first
//  PARITY | optional parity bit
//  STOP   | stop bit; RX finishes at its sample point
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_W     = 13
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [BAUD_W-1:0]             BAUD_VAL,
    input  logic                          PARITY_EN,
    input  logic                          ODD_N_EVEN,
    input  logic [DATA_W-1:0]             TX_DATA,
    input  logic                          TX_VALID,
    output logic                          TX_READY,
    output logic [DATA_W-1:0]             RX_DATA,
    output logic                          RX_VALID,
    input  logic                          RX_READY,
    output logic                          TX,
    input  logic                          RX,
    output logic                          TX_IDLE,
    output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
    output logic                          FRAMING_ERR,
    output logic                          PARITY_ERR,
    output logic                          OVERFLOW
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [BAUD_W-1:0] baud_cnt;
    logic              baud_tick;

    assign baud_tick = (baud_cnt == '0);

    // Reload value is read only at terminal count, so BAUD_VAL changes land there.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          baud_cnt <= '0;
        else if (baud_tick) baud_cnt <= BAUD_VAL;
        else                baud_cnt <= baud_cnt - BAUD_W'(1);
    end

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_fifo_data;
    logic [CNT_W-1:0]  tx_count;

    assign tx_push  = TX_VALID && !tx_full;
    assign TX_READY = !tx_full;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (tx_push),
        .wr_data (TX_DATA),
        .rd_en   (tx_pop),
        .rd_data (tx_fifo_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    tx_state_t         tx_state, tx_state_n;
    logic [TICK_W-1:0] tx_tick, tx_tick_n;
    logic [BIT_W-1:0]  tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              tx_par, tx_par_n;
    logic              tx_out_n;
    logic              tx_load;
    logic              tx_bit_end;

    assign tx_bit_end = baud_tick && (tx_tick == TICK_LAST);
    assign TX_IDLE    = (tx_count == '0) && (tx_state == TX_ST_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        tx_out_n   = 1'b1;

        if (tx_state != TX_ST_IDLE && baud_tick) tx_tick_n = tx_tick + TICK_ONE;

        case (tx_state)
            TX_ST_IDLE: begin
                if (baud_tick && !tx_empty) tx_load = 1'b1;
            end
            TX_ST_START: begin
                if (tx_bit_end) begin
                    tx_bit_n   = '0;
                    tx_state_n = TX_ST_DATA;
                end
            end
            TX_ST_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == BIT_LAST) tx_state_n = PARITY_EN ? TX_ST_PARITY : TX_ST_STOP;
                    else                    tx_bit_n   = tx_bit + BIT_ONE;
                end
            end
            TX_ST_PARITY: begin
                if (tx_bit_end) tx_state_n = TX_ST_STOP;
            end
            TX_ST_STOP: begin
                if (tx_bit_end) begin
                    if (!tx_empty) tx_load    = 1'b1;
                    else           tx_state_n = TX_ST_IDLE;
                end
            end
            default: tx_state_n = TX_ST_IDLE;
        endcase

        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_fifo_data;
            tx_par_n   = (^tx_fifo_data) ^ ODD_N_EVEN;
            tx_tick_n  = '0;
            tx_state_n = TX_ST_START;
        end

        // Line level follows the next state so TX comes straight from a flop.
        case (tx_state_n)
            TX_ST_START:  tx_out_n = 1'b0;
            TX_ST_DATA:   tx_out_n = tx_shift_n[0];
            TX_ST_PARITY: tx_out_n = tx_par_n;
            default:      tx_out_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_state <= TX_ST_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            TX       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            TX       <= tx_out_n;
        end
    end

    logic rx_meta, rx_sync, rx_prev, rx_fall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    logic rx_push, rx_pop, rx_full, rx_empty;

    assign RX_VALID = !rx_empty;
    assign rx_pop   = RX_READY && !rx_empty;

    rx_state_t         rx_state, rx_state_n;
    logic [TICK_W-1:0] rx_tick, rx_tick_n;
    logic [BIT_W-1:0]  rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic              rx_par, rx_par_n;
    logic              ferr_n, perr_n, ovf_n;
    logic              rx_sample, rx_bit_end;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (rx_push),
        .wr_data (rx_shift),
        .rd_en   (rx_pop),
        .rd_data (RX_DATA),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (RX_COUNT)
    );

    assign rx_sample  = baud_tick && (rx_tick == TICK_SAMPLE);
    assign rx_bit_end = baud_tick && (rx_tick == TICK_LAST);

    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        rx_push    = 1'b0;
        ferr_n     = 1'b0;
        perr_n     = 1'b0;
        ovf_n      = 1'b0;

        if (rx_state != RX_ST_IDLE && baud_tick) rx_tick_n = rx_tick + TICK_ONE;

        case (rx_state)
            RX_ST_IDLE: begin
                if (rx_fall) begin
                    rx_tick_n  = '0;
                    rx_state_n = RX_ST_START;
                end
            end
            RX_ST_START: begin
                if (rx_sample && rx_sync) begin
                    rx_state_n = RX_ST_IDLE;
                end else if (rx_bit_end) begin
                    rx_bit_n   = '0;
                    rx_state_n = RX_ST_DATA;
                end
            end
            RX_ST_DATA: begin
                if (rx_sample) rx_shift_n = {rx_sync, rx_shift[DATA_W-1:1]};
                if (rx_bit_end) begin
                    if (rx_bit == BIT_LAST) rx_state_n = PARITY_EN ? RX_ST_PARITY : RX_ST_STOP;
                    else                    rx_bit_n   = rx_bit + BIT_ONE;
                end
            end
            RX_ST_PARITY: begin
                if (rx_sample)  rx_par_n   = rx_sync;
                if (rx_bit_end) rx_state_n = RX_ST_STOP;
            end
            RX_ST_STOP: begin
                // Frame completes at mid-stop so the next start edge is never missed.
                if (rx_sample) begin
                    rx_state_n = RX_ST_IDLE;
                    if (!rx_full || rx_pop) rx_push = 1'b1;
                    else                    ovf_n   = 1'b1;
                    ferr_n = !rx_sync;
                    perr_n = PARITY_EN && (((^rx_shift) ^ ODD_N_EVEN) != rx_par);
                end
            end
            default: rx_state_n = RX_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_state    <= RX_ST_IDLE;
            rx_tick     <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            FRAMING_ERR <= 1'b0;
            PARITY_ERR  <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            rx_state    <= rx_state_n;
            rx_tick     <= rx_tick_n;
            rx_bit      <= rx_bit_n;
            rx_shift    <= rx_shift_n;
            rx_par      <= rx_par_n;
            FRAMING_ERR <= ferr_n;
            PARITY_ERR  <= perr_n;
            OVERFLOW    <= ovf_n;
        end
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: RX frame vector table plus TX, loopback, overflow and reset sequences.
module tb_uart_fifo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] baud_val;
    logic        parity_en, odd_n_even;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        tx_line, rx_line;
    logic        tx_idle;
    logic [2:0]  rx_count;
    logic        framing_err, parity_err, overflow;
    logic        loop, rx_drv;

    int checks   = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int ovf_cnt  = 0;

    assign rx_line = loop ? tx_line : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(.DATA_W(8), .FIFO_DEPTH(4), .BAUD_W(13)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .BAUD_VAL    (baud_val),
        .PARITY_EN   (parity_en),
        .ODD_N_EVEN  (odd_n_even),
        .TX_DATA     (tx_data),
        .TX_VALID    (tx_valid),
        .TX_READY    (tx_ready),
        .RX_DATA     (rx_data),
        .RX_VALID    (rx_valid),
        .RX_READY    (rx_ready),
        .TX          (tx_line),
        .RX          (rx_line),
        .TX_IDLE     (tx_idle),
        .RX_COUNT    (rx_count),
        .FRAMING_ERR (framing_err),
        .PARITY_ERR  (parity_err),
        .OVERFLOW    (overflow)
    );

    always @(negedge clk) begin
        if (framing_err === 1'b1) ferr_cnt++;
        if (parity_err === 1'b1)  perr_cnt++;
        if (overflow === 1'b1)    ovf_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit odd,
                              input bit flip, input bit stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit((^d) ^ odd ^ flip);
        drive_bit(stop);
        rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Checks each bit near both ends of its 16-cycle window (BAUD_VAL = 0).
    task automatic tx_expect(input string tag, input logic [7:0] d, input bit pen, input bit odd);
        logic exp_bits [11];
        int   nb;
        int   off;
        bit   seen;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
        nb = 9;
        if (pen) begin
            exp_bits[9] = (^d) ^ odd;
            nb = 10;
        end
        exp_bits[nb] = 1'b1;
        nb++;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_start_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            off = 0;
            for (int k = 0; k < nb; k++) begin
                while (off < 16*k + 1) begin @(negedge clk); off++; end
                check($sformatf("%s_bit%0d_early", tag, k), 32'(tx_line), 32'(exp_bits[k]));
                while (off < 16*k + 14) begin @(negedge clk); off++; end
                check($sformatf("%s_bit%0d_late", tag, k), 32'(tx_line), 32'(exp_bits[k]));
            end
            while (off < 16*nb + 1) begin @(negedge clk); off++; end
            check({tag, "_line_idle"}, 32'(tx_line), 32'd1);
            check({tag, "_tx_idle"}, 32'(tx_idle), 32'd1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         odd;
        bit         flip;
        bit         stop;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_perr;
    } rx_vec_t;

    rx_vec_t vecs [5];

    initial begin
        int f0, p0, o0, low_seen;
        logic [7:0] ovf_words [5];

        vecs[0] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 0, 0};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1, 0};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 0, 1};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 0};
        ovf_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst        = 1'b1;
        baud_val   = '0;
        parity_en  = 1'b0;
        odd_n_even = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        loop       = 1'b0;
        rx_drv     = 1'b1;

        #3;
        check("rst_tx", 32'(tx_line), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_errs", 32'({framing_err, parity_err, overflow}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 8N1 transmit of 0xA5
        push(8'hA5);
        tx_expect("tx_a5", 8'hA5, 1'b0, 1'b0);

        // loopback with odd parity
        loop = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
        f0 = ferr_cnt; p0 = perr_cnt; o0 = ovf_cnt;
        push(8'h03);
        tx_expect("loop_03", 8'h03, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("loop_rx_valid", 32'(rx_valid), 32'd1);
        check("loop_rx_data", 32'(rx_data), 32'h03);
        check("loop_errs", 32'((ferr_cnt - f0) + (perr_cnt - p0) + (ovf_cnt - o0)), 32'd0);
        pop();
        loop = 1'b0;

        // RX frame vectors
        for (int i = 0; i < 5; i++) begin
            parity_en  = vecs[i].pen;
            odd_n_even = vecs[i].odd;
            f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].odd, vecs[i].flip, vecs[i].stop);
            check($sformatf("vec%0d_rx_valid", i), 32'(rx_valid), 32'd1);
            check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_rx_count", i), 32'(rx_count), 32'd1);
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_perr", i), 32'(perr_cnt - p0), 32'(vecs[i].exp_perr));
            pop();
            check($sformatf("vec%0d_count_after_pop", i), 32'(rx_count), 32'd0);
        end

        // overflow on the fifth frame into a 4-deep RX FIFO
        parity_en = 1'b0; odd_n_even = 1'b0;
        o0 = ovf_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        for (int i = 0; i < 5; i++) send_frame(ovf_words[i], 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_rx_count", 32'(rx_count), 32'd4);
        check("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
        check("ovf_other_errs", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_pop%0d_valid", i), 32'(rx_valid), 32'd1);
            check($sformatf("ovf_pop%0d_data", i), 32'(rx_data), 32'(ovf_words[i]));
            pop();
        end
        check("ovf_drained", 32'(rx_valid), 32'd0);

        // false start: 4 ticks low
        f0 = ferr_cnt; p0 = perr_cnt; o0 = ovf_cnt;
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("fs_rx_count", 32'(rx_count), 32'd0);
        check("fs_rx_valid", 32'(rx_valid), 32'd0);
        check("fs_errs", 32'((ferr_cnt - f0) + (perr_cnt - p0) + (ovf_cnt - o0)), 32'd0);

        // reset in the middle of a TX data bit with words queued
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (40) @(posedge clk);
        #2;
        check("pre_rst_tx_busy", 32'(tx_idle), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx_line), 32'd1);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_tx_idle", 32'(tx_idle), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        low_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_line !== 1'b1) low_seen++;
        end
        check("post_rst_line_quiet", 32'(low_seen), 32'd0);
        check("post_rst_rx_count", 32'(rx_count), 32'd0);
        #1;
        push(8'hC3);
        tx_expect("post_rst_c3", 8'hC3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 Parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO; must be a power of 2, at least 2.
REQ-003 Parameter BAUD_W, default 13, meaning width of BAUD_VAL.
REQ-004 CLK  in  1  single clock for all logic; all state changes on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 BAUD_VAL  in  BAUD_W  16x oversample tick period minus one, in CLK cycles.
REQ-007 PARITY_EN  in  1  adds a parity bit after the data bits.
REQ-008 ODD_N_EVEN  in  1  1 = odd parity, 0 = even parity.
REQ-009 TX_DATA  in  DATA_W  write data; TX_VALID  in  1  write request; TX_READY  out  1  high when the TX FIFO is not full.
REQ-010 RX_DATA  out  DATA_W  head of the RX FIFO; RX_VALID  out  1  high when the RX FIFO is not empty; RX_READY  in  1  pop request.
REQ-011 TX  out  1  serial output; RX  in  1  serial input, asynchronous to CLK.
REQ-012 TX_IDLE  out  1  high when the TX FIFO is empty and the TX FSM is in IDLE.
REQ-013 RX_COUNT  out  clog2(FIFO_DEPTH)+1  current RX FIFO occupancy.
REQ-014 FRAMING_ERR, PARITY_ERR, OVERFLOW  out  1 each  one-cycle error pulses.

Function
REQ-015 The baud counter SHALL count down from BAUD_VAL and emit a 1-cycle tick on reaching 0, then reload; BAUD_VAL=0 gives a tick every cycle.
REQ-016 One bit period SHALL be 16 ticks; frame = start(0), DATA_W bits LSB first, optional parity, one stop(1).
REQ-017 A TX push SHALL occur on TX_VALID&&TX_READY; with the FIFO full the push is ignored even if a pop occurs in the same cycle.
REQ-018 TX FSM states: IDLE, START, DATA, PARITY, STOP; in IDLE with the FIFO non-empty it pops one word and enters START on the next tick.
REQ-019 PARITY SHALL be skipped when PARITY_EN=0; the parity bit = XOR(data) XOR ODD_N_EVEN.
REQ-020 On leaving STOP after 16 ticks, the TX FSM SHALL go to START if the FIFO is non-empty (back-to-back frames, no idle gap), else to IDLE.
REQ-021 RX SHALL pass through a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-022 RX FSM states: IDLE, START, DATA, PARITY, STOP; a synchronised 1->0 edge in IDLE enters START with the tick count cleared.
REQ-023 Each bit SHALL be sampled at its 8th tick; in START, a sample of 1 is a false start: return to IDLE with no output.
REQ-024 At the STOP sample, the FSM SHALL write the frame to the RX FIFO if not full, or else drop it and pulse OVERFLOW.
REQ-025 At the STOP sample, it SHALL pulse FRAMING_ERR if the stop bit = 0 (frame still written), and pulse PARITY_ERR on parity mismatch (frame still written).
REQ-026 The RX FSM SHALL return to IDLE at the STOP sample, ready for a new start edge.
REQ-027 An RX pop SHALL occur on RX_VALID&&RX_READY; a pop and push in the same cycle leave RX_COUNT unchanged; when full, a simultaneous pop+push is accepted.
REQ-028 RX_DATA SHALL be the FIFO head with zero-latency (show-ahead) timing; its value is undefined when RX_VALID=0.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL come from an extra pointer MSB.
REQ-030 A BAUD_VAL change SHALL take effect at the next counter reload.

Reset
REQ-031 RESET assertion SHALL immediately force: TX=1, TX_READY=1, TX_IDLE=1, RX_VALID=0, RX_COUNT=0, all error pulses 0, both FSMs IDLE, both FIFOs empty, baud counter and synchroniser flops set to 1/idle values.
REQ-032 A frame in progress at RESET SHALL be abandoned; no partial frame is emitted or stored after release.
REQ-033 After RESET deasserts, operation SHALL begin on the first CLK edge with no extra wait cycles.

Structure
REQ-034 A shared package uart_pkg SHALL hold the TX/RX state enums, the oversample constant (16) and the sample point constant (8).
REQ-035 One sub-module, uart_sync_fifo (params WIDTH, DEPTH), SHALL be instantiated twice, once for TX and once for RX; the baud generator and both FSMs stay in the top module.

Verification
REQ-036 Test: BAUD_VAL=0, 8N1, push 0xA5 -> TX low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16; TX_IDLE returns to 1.
REQ-037 Test: TX looped to RX, PARITY_EN=1, ODD_N_EVEN=1, push 0x03 -> parity bit = 1; RX_DATA=0x03 with RX_VALID, and no error pulses.
REQ-038 Test: FIFO_DEPTH=4, send 5 frames with RX_READY=0 -> RX_COUNT=4, OVERFLOW pulses once on the 5th frame, and pops return frames 1-4 in order.
REQ-039 Test: drive the stop bit low on frame 0x5A -> FRAMING_ERR pulses once and 0x5A is stored.
REQ-040 Test: RX low for 4 ticks then high -> false start; RX_COUNT stays 0 and no error pulses occur.
REQ-041 Test: assert RESET mid-DATA of a TX frame and push 4 words -> TX=1 and TX_READY=1 immediately; after release the next pushed word is sent cleanly.
